// File: rtl/mips_mc_controller_if.sv
// Control bundle between the multicycle MIPS controller and its datapath.
// The controller (master) reads instruction fields and zero, and drives every control line.
interface mips_mc_controller_if #(
  parameter int OP_W = 6
);
  logic [OP_W-1:0] op;
  logic [OP_W-1:0] funct;
  logic            zero;
  logic            pcen;
  logic            memwrite;
  logic            irwrite;
  logic            regwrite;
  logic            iord;
  logic            alusrca;
  logic [1:0]      alusrcb;
  logic [1:0]      pcsrc;
  logic            memtoreg;
  logic            regdst;
  logic [2:0]      alucontrol;
  logic            sign_extend_enb;
  logic            done;
  logic            illegal;

  modport master (
    input  op, funct, zero,
    output pcen, memwrite, irwrite, regwrite, iord, alusrca, alusrcb, pcsrc,
           memtoreg, regdst, alucontrol, sign_extend_enb, done, illegal
  );

  modport slave (
    output op, funct, zero,
    input  pcen, memwrite, irwrite, regwrite, iord, alusrca, alusrcb, pcsrc,
           memtoreg, regdst, alucontrol, sign_extend_enb, done, illegal
  );
endinterface

// File: rtl/mips_mc_controller.sv
// Moore control FSM for the multicycle MIPS datapath: lw/sw, R-type, beq/bne, addi, ori, j.
// Outputs decode from the state; only pcen in BRANCH also looks at op and zero.
module mips_mc_controller #(
  parameter logic [3:0] RESET_STATE = 4'd0,
  parameter int         OP_W        = 6
) (
  input  logic                 clk,
  input  logic                 reset,
  mips_mc_controller_if.master bus
);

  typedef enum logic [3:0] {
    FETCH   = 4'd0,  DECODE  = 4'd1,  MEMADR = 4'd2,  MEMRD  = 4'd3,
    MEMWB   = 4'd4,  MEMWR   = 4'd5,  EXECUTE = 4'd6, ALUWB  = 4'd7,
    BRANCH  = 4'd8,  ADDIEX  = 4'd9,  ORIEX  = 4'd10, IMMWB  = 4'd11,
    JUMP    = 4'd12, ILLEGAL = 4'd13
  } state_t;

  localparam logic [OP_W-1:0] OP_RTYPE = 6'b000000;
  localparam logic [OP_W-1:0] OP_LW    = 6'b100011;
  localparam logic [OP_W-1:0] OP_SW    = 6'b101011;
  localparam logic [OP_W-1:0] OP_BEQ   = 6'b000100;
  localparam logic [OP_W-1:0] OP_BNE   = 6'b000101;
  localparam logic [OP_W-1:0] OP_ADDI  = 6'b001000;
  localparam logic [OP_W-1:0] OP_ORI   = 6'b001101;
  localparam logic [OP_W-1:0] OP_J     = 6'b000010;

  // Returns {legal, alucontrol} for an R-type funct field.
  function automatic logic [3:0] alu_decode(input logic [OP_W-1:0] f);
    case (f)
      6'b100000: alu_decode = 4'b1_010;
      6'b100010: alu_decode = 4'b1_110;
      6'b100100: alu_decode = 4'b1_000;
      6'b100101: alu_decode = 4'b1_001;
      6'b101010: alu_decode = 4'b1_111;
      default:   alu_decode = 4'b0_000;
    endcase
  endfunction

  state_t     state_r;
  state_t     next_state_s;
  state_t     out_state_s;
  logic [3:0] alu_dec_s;

  assign alu_dec_s = alu_decode(bus.funct);

  // State register; reset wins over every transition.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= state_t'(RESET_STATE);
    end else begin
      state_r <= next_state_s;
    end
  end

  // Next-state and output decode.
  always_comb begin
    next_state_s        = FETCH;
    bus.pcen            = 1'b0;
    bus.memwrite        = 1'b0;
    bus.irwrite         = 1'b0;
    bus.regwrite        = 1'b0;
    bus.iord            = 1'b0;
    bus.alusrca         = 1'b0;
    bus.alusrcb         = 2'b00;
    bus.pcsrc           = 2'b00;
    bus.memtoreg        = 1'b0;
    bus.regdst          = 1'b0;
    bus.alucontrol      = 3'b000;
    bus.sign_extend_enb = 1'b1;
    bus.done            = 1'b0;
    bus.illegal         = 1'b0;

    // During reset the datapath sees FETCH steering with every enable held low.
    if (reset) begin
      out_state_s = FETCH;
    end else begin
      out_state_s = state_r;
    end

    case (state_r)
      FETCH:   next_state_s = DECODE;
      DECODE: begin
        case (bus.op)
          OP_LW, OP_SW:   next_state_s = MEMADR;
          OP_RTYPE: begin
            if (alu_dec_s[3]) begin
              next_state_s = EXECUTE;
            end else begin
              next_state_s = ILLEGAL;
            end
          end
          OP_BEQ, OP_BNE: next_state_s = BRANCH;
          OP_ADDI:        next_state_s = ADDIEX;
          OP_ORI:         next_state_s = ORIEX;
          OP_J:           next_state_s = JUMP;
          default:        next_state_s = ILLEGAL;
        endcase
      end
      MEMADR: begin
        if (bus.op == OP_SW) begin
          next_state_s = MEMWR;
        end else begin
          next_state_s = MEMRD;
        end
      end
      MEMRD:   next_state_s = MEMWB;
      EXECUTE: next_state_s = ALUWB;
      ADDIEX:  next_state_s = IMMWB;
      ORIEX:   next_state_s = IMMWB;
      ILLEGAL: next_state_s = ILLEGAL;
      default: next_state_s = FETCH;
    endcase

    case (out_state_s)
      FETCH: begin
        bus.alusrcb = 2'b01; bus.alucontrol = 3'b010;
        bus.irwrite = 1'b1;  bus.pcen = 1'b1;
      end
      DECODE: begin
        bus.alusrcb = 2'b11; bus.alucontrol = 3'b010;
      end
      MEMADR, ADDIEX: begin
        bus.alusrca = 1'b1; bus.alusrcb = 2'b10; bus.alucontrol = 3'b010;
      end
      MEMRD: bus.iord = 1'b1;
      MEMWB: begin
        bus.memtoreg = 1'b1; bus.regwrite = 1'b1; bus.done = 1'b1;
      end
      MEMWR: begin
        bus.iord = 1'b1; bus.memwrite = 1'b1; bus.done = 1'b1;
      end
      EXECUTE: begin
        bus.alusrca = 1'b1; bus.alucontrol = alu_dec_s[2:0];
      end
      ALUWB: begin
        bus.regdst = 1'b1; bus.regwrite = 1'b1; bus.done = 1'b1;
      end
      BRANCH: begin
        bus.alusrca = 1'b1; bus.alucontrol = 3'b110;
        bus.pcsrc   = 2'b01; bus.done = 1'b1;
        if (bus.op == OP_BNE) begin
          bus.pcen = ~bus.zero;
        end else begin
          bus.pcen = bus.zero;
        end
      end
      ORIEX: begin
        bus.alusrca = 1'b1; bus.alusrcb = 2'b10; bus.alucontrol = 3'b001;
        bus.sign_extend_enb = 1'b0;
      end
      IMMWB: begin
        bus.regwrite = 1'b1; bus.done = 1'b1;
      end
      JUMP: begin
        bus.pcsrc = 2'b10; bus.pcen = 1'b1; bus.done = 1'b1;
      end
      ILLEGAL: bus.illegal = 1'b1;
      default: bus.illegal = 1'b0;
    endcase

    if (reset) begin
      bus.pcen     = 1'b0;
      bus.memwrite = 1'b0;
      bus.irwrite  = 1'b0;
      bus.regwrite = 1'b0;
      bus.done     = 1'b0;
    end else begin
      bus.illegal = bus.illegal;
    end
  end

endmodule

// File: doc/mips_mc_controller.md
Name: mips_mc_controller

Overview:
Multicycle MIPS control unit that drives every control input of the multicycle datapath from the fetched instruction's op/funct fields and the ALU zero flag. It is a Moore FSM with combinational ALU-control decode and branch gating for pcen. It sits beside the datapath and memory interface in the multicycle MIPS top level. It supports lw, sw, R-type (add, sub, and, or, slt), beq, bne, addi, ori (zero-extended immediate) and j.

Parameters:
RESET_STATE, 4'd0, state entered on reset (FETCH); other values are unsupported.
OP_W, 6, opcode/funct field width.

Ports:
clk  input  1  system clock; all state updates on rising edge.
reset  input  1  synchronous, active-high reset.
op  input  6  instr[31:26] from the instruction register.
funct  input  6  instr[5:0] from the instruction register.
zero  input  1  ALU zero flag.
pcen  output  1  PC register enable.
memwrite  output  1  memory write strobe.
irwrite  output  1  instruction register load.
regwrite  output  1  register file write enable.
iord  output  1  memory address select (0 = pc, 1 = aluout).
alusrca  output  1  ALU A select (0 = pc, 1 = register rs).
alusrcb  output  2  ALU B select: 00 = rt, 01 = 4, 10 = signimm, 11 = signimm<<2.
pcsrc  output  2  next-PC select: 00 = ALU result, 01 = aluout register, 10 = jump target.
memtoreg  output  1  write-back select (1 = readdata).
regdst  output  1  destination register select (1 = rd).
alucontrol  output  3  ALU function code.
sign_extend_enb  output  1  1 = sign-extend immediate, 0 = zero-extend.
done  output  1  one-cycle pulse in the last state of each instruction.
illegal  output  1  high while in ILLEGAL state.

Behaviour:
- State register is 4 bits. Synchronous reset: state <= FETCH, and this takes priority over all transitions, including mid-instruction.
- While reset=1, pcen, memwrite, irwrite, regwrite and done are forced to 0. All other outputs take their FETCH values.
- Outputs not listed for a state are 0. sign_extend_enb is 1 in every state except ORIEX.
- State table (state: outputs; next state):
  - FETCH: iord=0, alusrca=0, alusrcb=01, ALU add, pcsrc=00, irwrite=1, pcen=1; next DECODE.
  - DECODE: alusrca=0, alusrcb=11, ALU add (branch target into aluout). Next by op:
    - 100011 or 101011 -> MEMADR
    - 000000 -> EXECUTE, but only for a legal funct; otherwise ILLEGAL
    - 000100 or 000101 -> BRANCH
    - 001000 -> ADDIEX
    - 001101 -> ORIEX
    - 000010 -> JUMP
    - anything else -> ILLEGAL
  - MEMADR: alusrca=1, alusrcb=10, ALU add; lw -> MEMRD, sw -> MEMWR.
  - MEMRD: iord=1; next MEMWB.
  - MEMWB: regdst=0, memtoreg=1, regwrite=1, done=1; next FETCH.
  - MEMWR: iord=1, memwrite=1, done=1; next FETCH.
  - EXECUTE: alusrca=1, alusrcb=00, ALU per funct; next ALUWB.
  - ALUWB: regdst=1, memtoreg=0, regwrite=1, done=1; next FETCH.
  - BRANCH: alusrca=1, alusrcb=00, ALU sub, pcsrc=01, done=1. pcen = zero for beq, ~zero for bne. Next FETCH.
  - ADDIEX: alusrca=1, alusrcb=10, ALU add; next IMMWB.
  - ORIEX: alusrca=1, alusrcb=10, ALU or, sign_extend_enb=0; next IMMWB.
  - IMMWB: regdst=0, memtoreg=0, regwrite=1, done=1; next FETCH.
  - JUMP: pcsrc=10, pcen=1, done=1; next FETCH.
  - ILLEGAL: illegal=1, all enables 0; remains in ILLEGAL until reset.
- ALU codes: add=010, sub=110, and=000, or=001, slt=111.
- R-type funct map: 100000 add, 100010 sub, 100100 and, 100101 or, 101010 slt. Any other funct is illegal.
- Cycle counts (FETCH through done): lw 5; sw, R-type, addi, ori 4; beq, bne, j 3.
- pcen is the only output that depends combinationally on zero or op.
- Unused state encodings (14, 15) transition to FETCH with all enables 0.

Test Plan:
- Reset: hold reset for 2 cycles -> pcen=irwrite=regwrite=memwrite=0 throughout. After release, first cycle is FETCH: irwrite=1, pcen=1, alusrcb=01, alucontrol=010.
- lw (op=100011): FETCH, DECODE, MEMADR (alusrcb=10), MEMRD (iord=1), MEMWB (regwrite=1, memtoreg=1, done=1); 5 cycles, then FETCH. sw (op=101011): memwrite=1 in cycle 4, regwrite never 1.
- R-type, op=000000: funct=100010 -> EXECUTE alucontrol=110, ALUWB regdst=1. funct=101010 -> alucontrol=111. funct=000000 -> DECODE goes to ILLEGAL, illegal=1 and held.
- Branch, in the BRANCH state:
  - beq with zero=1 -> pcen=1, pcsrc=01.
  - beq with zero=0 -> pcen=0.
  - bne (000101) with zero=0 -> pcen=1.
  - bne with zero=1 -> pcen=0.
- ori (001101): ORIEX has sign_extend_enb=0, alucontrol=001; IMMWB has regwrite=1, regdst=0. addi (001000): sign_extend_enb=1 throughout, alucontrol=010.
- Mid-instruction reset and illegal recovery:
  - Assert reset during MEMRD of lw -> next cycle is FETCH and no MEMWB regwrite pulse occurs.
  - Assert reset while in ILLEGAL -> returns to FETCH.
  - j (000010): JUMP has pcsrc=10, pcen=1, done=1.
